// File: rtl/fp16_acc.sv
// Sequential FP16 accumulator: each accepted term passes through ALIGN, ADD and NORM,
// and the running sum is presented in OUT after the term flagged as last.
module fp16_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);
    typedef enum logic [2:0] {IDLE = 3'd0, ALIGN = 3'd1, ADD = 3'd2, NORM = 3'd3, OUT = 3'd4} state_t;

    state_t        state_reg, state_next;
    logic [15:0]   acc_reg, term_reg, out_data_reg, byp_val_reg;
    logic          last_reg, byp_reg, sa_reg, sb_reg, sum_sign_reg;
    logic [13:0]   ma_reg, mb_reg;
    logic [4:0]    emax_reg;
    logic [14:0]   sum_reg;

    logic [4:0]    acc_exp, term_exp, exp_diff, emax_next;
    logic [13:0]   acc_mant, term_mant, ma_next, mb_next;
    logic          byp_next;
    logic [15:0]   byp_val_next;
    logic [14:0]   sum_next;
    logic          sum_sign_next;
    logic [3:0]    lead;
    logic signed [6:0] e_norm;
    logic [9:0]    frac_norm;
    logic [15:0]   norm_result;

    // Alignment; infinity in either operand or a zero term bypasses the arithmetic
    always_comb begin
        acc_exp   = acc_reg[14:10];
        term_exp  = term_reg[14:10];
        acc_mant  = (acc_exp == 5'd0) ? 14'd0 : {1'b1, acc_reg[9:0], 3'b000};
        term_mant = (term_exp == 5'd0) ? 14'd0 : {1'b1, term_reg[9:0], 3'b000};
        if (acc_exp >= term_exp) begin
            emax_next = acc_exp;
            exp_diff  = acc_exp - term_exp;
            ma_next   = acc_mant;
            mb_next   = (exp_diff >= 5'd14) ? 14'd0 : (term_mant >> exp_diff);
        end else begin
            emax_next = term_exp;
            exp_diff  = term_exp - acc_exp;
            ma_next   = (exp_diff >= 5'd14) ? 14'd0 : (acc_mant >> exp_diff);
            mb_next   = term_mant;
        end
        byp_next     = 1'b0;
        byp_val_next = acc_reg;
        if (acc_exp == 5'h1f) begin
            byp_next = 1'b1;
        end else if (term_exp == 5'h1f) begin
            byp_next     = 1'b1;
            byp_val_next = {term_reg[15], 5'h1f, 10'h000};
        end else if (term_exp == 5'd0) begin
            byp_next = 1'b1;
        end
    end

    always_comb begin
        sum_next      = 15'd0;
        sum_sign_next = 1'b0;
        if (sa_reg == sb_reg) begin
            sum_next      = {1'b0, ma_reg} + {1'b0, mb_reg};
            sum_sign_next = sa_reg;
        end else if (ma_reg > mb_reg) begin
            sum_next      = {1'b0, ma_reg} - {1'b0, mb_reg};
            sum_sign_next = sa_reg;
        end else if (mb_reg > ma_reg) begin
            sum_next      = {1'b0, mb_reg} - {1'b0, ma_reg};
            sum_sign_next = sb_reg;
        end
    end

    // Leading-one normalize; the leading one lands at bit 14 before the fraction is cut
    always_comb begin
        lead = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (sum_reg[i]) lead = 4'(i);
        end
        e_norm    = $signed({2'b00, emax_reg}) + $signed({3'b000, lead}) - 7'sd13;
        frac_norm = 10'((sum_reg << (4'd14 - lead)) >> 4);
        if (byp_reg)
            norm_result = byp_val_reg;
        else if (sum_reg == 15'd0 || e_norm < 7'sd1)
            norm_result = 16'h0000;
        else if (e_norm > 7'sd30)
            norm_result = {sum_sign_reg, 5'h1f, 10'h000};
        else
            norm_result = {sum_sign_reg, e_norm[4:0], frac_norm};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = last_reg ? OUT : IDLE;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst && (state_reg == IDLE);
        out_valid = (state_reg == OUT);
        out_data  = out_data_reg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg      <= 16'h0000;
            term_reg     <= 16'h0000;
            out_data_reg <= 16'h0000;
            byp_val_reg  <= 16'h0000;
            last_reg     <= 1'b0;
            byp_reg      <= 1'b0;
            sa_reg       <= 1'b0;
            sb_reg       <= 1'b0;
            sum_sign_reg <= 1'b0;
            ma_reg       <= 14'd0;
            mb_reg       <= 14'd0;
            emax_reg     <= 5'd0;
            sum_reg      <= 15'd0;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
                    term_reg <= in_data;
                    last_reg <= in_last;
                end
                ALIGN: begin
                    ma_reg      <= ma_next;
                    mb_reg      <= mb_next;
                    sa_reg      <= acc_reg[15];
                    sb_reg      <= term_reg[15];
                    emax_reg    <= emax_next;
                    byp_reg     <= byp_next;
                    byp_val_reg <= byp_val_next;
                end
                ADD: begin
                    sum_reg      <= sum_next;
                    sum_sign_reg <= sum_sign_next;
                end
                NORM: begin
                    acc_reg <= norm_result;
                    if (last_reg) out_data_reg <= norm_result;
                end
                OUT: if (out_ready) acc_reg <= 16'h0000;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_acc.sv
// Randomized bench for fp16_acc against an integer-arithmetic model of the FP16 sum.
module tb_fp16_acc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [15:0] in_data, out_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] model_acc = 16'h0000;
    logic [15:0] exp_q[$];

    fp16_acc dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact value as integer scaled by 2^(emax-28); smaller operand truncated, result cut to 10 bits
    function automatic logic [15:0] fp_add(input logic [15:0] a, input logic [15:0] t);
        int ea, et, emax, e;
        longint va, vt, s, mag;
        logic sg;
        ea = int'(a[14:10]);
        et = int'(t[14:10]);
        if (ea == 31) return a;
        if (et == 31) return {t[15], 5'h1f, 10'h000};
        if (et == 0) return a;
        emax = (ea > et) ? ea : et;
        va = (ea == 0) ? 0 : ((longint'(a[9:0]) + 1024) * 8) / (longint'(1) << (emax - ea));
        vt = ((longint'(t[9:0]) + 1024) * 8) / (longint'(1) << (emax - et));
        s = (a[15] ? -va : va) + (t[15] ? -vt : vt);
        if (s == 0) return 16'h0000;
        sg  = (s < 0);
        mag = sg ? -s : s;
        e   = emax;
        while (mag >= 16384) begin mag = mag / 2; e++; end
        while (mag < 8192) begin mag = mag * 2; e--; end
        if (e < 1) return 16'h0000;
        if (e > 30) return {sg, 5'h1f, 10'h000};
        return {sg, 5'(e), 10'((mag / 8) % 1024)};
    endfunction

    function automatic logic [15:0] rand_term(input int base);
        int r, e;
        r = int'($urandom_range(0, 19));
        if (r == 0)      e = 0;
        else if (r == 1) e = 31;
        else begin
            e = base + int'($urandom_range(0, 6)) - 3;
            if (e < 1) e = 1;
            if (e > 30) e = 30;
        end
        return {1'($urandom), 5'(e), 10'($urandom)};
    endfunction

    // Called just after a negedge; returns just after a negedge
    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        while (!in_ready && n < 40) begin
            in_valid = 1'($urandom); in_data = 16'($urandom); in_last = 1'($urandom);
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0, required 1");
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1; in_data = d; in_last = l;
        @(posedge clk);
        #1;
        model_acc = fp_add(model_acc, d);
        if (l) begin
            exp_q.push_back(model_acc);
            model_acc = 16'h0000;
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'($urandom); in_data = 16'($urandom); in_last = 1'($urandom);
            @(negedge clk);
            if (l) begin
                check("last_ready_low", {15'd0, in_ready}, 16'd0);
                check("out_valid_timing", {15'd0, out_valid}, {15'd0, k == 3});
            end else begin
                check("ready_timing", {15'd0, in_ready}, {15'd0, k == 3});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic collect(input int hold, output logic [15:0] d);
        int n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (!out_valid) begin
            n_checks++; n_fail++;
            $display("FAIL collect_timeout: out_valid stayed 0, required 1");
            d = 16'hxxxx;
            return;
        end
        d = out_data;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom); in_data = 16'($urandom); in_last = 1'($urandom);
            @(negedge clk);
            check("hold_valid", {15'd0, out_valid}, 16'd1);
            check("hold_data", out_data, d);
            check("hold_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        check("out_drop", {15'd0, out_valid}, 16'd0);
        check("out_keep", out_data, d);
        check("ready_after_out", {15'd0, in_ready}, 16'd1);
    endtask

    // Scoreboard compare on every cycle a result is presented
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL spurious_out: out_valid 1 with no result expected");
            end else begin
                check("model_out", out_data, exp_q[0]);
                check("ready_in_out", {15'd0, in_ready}, 16'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        int len, base;
        rst = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_out_data", out_data, 16'h0000);
        rst = 1'b1;
        #1 check("first_ready", {15'd0, in_ready}, 16'd1);

        send(16'h3C00, 1'b0); send(16'h3C00, 1'b1); collect(0, d); check("one_plus_one", d, 16'h4000);
        send(16'h3E00, 1'b0); send(16'hBE00, 1'b1); collect(1, d); check("cancel", d, 16'h0000);
        send(16'h0001, 1'b0); send(16'h3C00, 1'b1); collect(0, d); check("ftz", d, 16'h3C00);
        send(16'h3C00, 1'b0); send(16'h1400, 1'b1); collect(0, d); check("ulp_add", d, 16'h3C01);
        send(16'h3C00, 1'b0); send(16'h0C00, 1'b1); collect(2, d); check("trunc", d, 16'h3C00);
        send(16'h7800, 1'b0); send(16'h7800, 1'b0); send(16'hBC00, 1'b1); collect(0, d);
        check("sticky_inf", d, 16'h7C00);
        send(16'h3C00, 1'b1); collect(5, d); check("held_result", d, 16'h3C00);
        send(16'h4200, 1'b1); collect(0, d); check("acc_cleared", d, 16'h4200);

        // Reset while the term sits in ADD
        in_valid = 1'b1; in_data = 16'h3E00; in_last = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ready", {15'd0, in_ready}, 16'd0);
        check("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        check("mid_rst_data", out_data, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        #1 check("rst_release_ready", {15'd0, in_ready}, 16'd1);
        send(16'h3C00, 1'b1); collect(0, d); check("after_rst", d, 16'h3C00);

        for (int s = 0; s < 60; s++) begin
            len  = int'($urandom_range(1, 5));
            base = (s % 4 == 0) ? 29 : (s % 4 == 1) ? 2 : int'($urandom_range(1, 30));
            for (int j = 0; j < len; j++) send(rand_term(base), j == len - 1);
            collect(int'($urandom_range(0, 3)), d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp16_acc.md
FP16_ACC -- requirements
Module: fp16_acc

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-low (rst=0 resets).
REQ-003 The block SHALL have the port in_valid, input, 1 bit: an FP16 term is present on in_data.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-005 The block SHALL have the port in_data, input, 16 bits: an FP16 term (sign[15], exp[14:10] bias 15, frac[9:0]), typically the product from the FP16 multiplier pipeline.
REQ-006 The block SHALL have the port in_last, input, 1 bit: the accepted term is the final term of the sum.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: out_data holds a completed sum.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: the consumer takes out_data.
REQ-009 The block SHALL have the port out_data, output, 16 bits: the FP16 accumulated sum.

Function
REQ-010 The block SHALL implement the FSM states IDLE, ALIGN, ADD, NORM and OUT.
REQ-011 in_ready SHALL equal (state==IDLE); an input handshake SHALL be in_valid and in_ready at a rising edge.
REQ-012 On the handshake, the block SHALL latch the term and in_last, then step IDLE->ALIGN->ADD->NORM, one cycle per state.
REQ-013 On leaving NORM, the accumulator SHALL be updated; the next state SHALL be OUT if the latched last=1, else IDLE.
REQ-014 Throughput SHALL be one term per 4 cycles; in_ready SHALL be high again 4 edges after acceptance when the term was not last.
REQ-015 In OUT, out_valid SHALL be 1 and out_data SHALL equal the accumulator, both stable until out_ready=1 at an edge.
REQ-016 On the OUT handshake, the accumulator SHALL clear to +0 and the state SHALL return to IDLE.
REQ-017 Outside OUT, out_valid SHALL be 0; out_data SHALL hold its last value.
REQ-018 Any operand with exp==0 SHALL be treated as zero (flush-to-zero); frac SHALL be ignored.
REQ-019 ALIGN: the mantissas SHALL be formed as {1,frac,3'b000} (14 bits), and the smaller-exponent mantissa SHALL be right-shifted by the exponent difference.
REQ-020 ALIGN: a shift of 14 or more SHALL yield 0, and bits shifted out SHALL be discarded (truncation).
REQ-021 ADD: equal signs SHALL add the magnitudes (15-bit result).
REQ-022 ADD: differing signs SHALL subtract the smaller magnitude from the larger, with the result taking the sign of the larger; on equal magnitudes the result SHALL be +0.
REQ-023 NORM: a single-cycle leading-one detect SHALL normalize with the exponent adjusted, and the fraction SHALL be truncated to 10 bits (round toward zero).
REQ-024 NORM: a normalized exponent below 1 SHALL yield +0.
REQ-025 Overflow: a normalized exponent above 30 SHALL yield infinity (exp 31, frac 0) with the result sign.
REQ-026 An input with exp==31 SHALL be treated as infinity of its sign.
REQ-027 Once the accumulator is infinity, it SHALL remain unchanged by further terms until cleared by the OUT handshake.
REQ-028 A zero term SHALL still consume 4 cycles and SHALL leave the accumulator unchanged (-0 SHALL never be produced).
REQ-029 in_valid while not in IDLE SHALL be ignored, and in_data SHALL NOT be sampled.

Reset
REQ-030 While rst=0, the block SHALL force state=IDLE, accumulator=+0, out_valid=0 and out_data=16'h0000, and in_ready SHALL be 0.
REQ-031 Reset asserted mid-operation (any state, including OUT) SHALL discard the in-flight term and pending result immediately and asynchronously.
REQ-032 The first edge after rst rises SHALL see in_ready=1.

Verification
REQ-033 The bench SHALL cover: 0x3C00, then 0x3C00 with last -> out_data 0x4000, out_valid high after the 8th edge from the first acceptance.
REQ-034 The bench SHALL cover: 0x3E00, then 0xBE00 last -> 0x0000; and 0x0001, then 0x3C00 last -> 0x3C00 (flush-to-zero).
REQ-035 The bench SHALL cover: 0x3C00, then 0x1400 (2^-10) last -> 0x3C01; and 0x3C00, then 0x0C00 (2^-12) last -> 0x3C00 (truncated).
REQ-036 The bench SHALL cover: 0x7800, then 0x7800, then 0xBC00 last -> 0x7C00 (sticky overflow).
REQ-037 The bench SHALL cover: result pending with out_ready low 5 cycles -> out_valid and out_data stable and in_ready 0; after the handshake, 0x4200 last -> 0x4200 (accumulator cleared).
REQ-038 The bench SHALL cover: rst pulsed low while in ADD -> outputs 0 at once; then 0x3C00 last -> 0x3C00.
